// File: rtl/asc_word_to_hex_stream_if.sv
// Handshake bundle for the word-to-hex serializer: word input side and ASCII byte output side.
interface asc_word_to_hex_stream_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_char;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_char, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_char, out_valid
  );
endinterface

// File: rtl/asc_word_to_hex_stream.sv
// Serializes a WIDTH-bit word into ASCII hex characters, MS nybble first,
// with optional "0x" prefix and trailing separator.
module asc_word_to_hex_stream #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          UPPER     = 1'b1,
  parameter bit          PREFIX_EN = 1'b0,
  parameter bit          SEP_EN    = 1'b1,
  parameter logic [7:0]  SEP_CHAR  = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  asc_word_to_hex_stream_if.slave   bus
);

  localparam int unsigned NDIG = WIDTH / 4;

  typedef enum logic [2:0] {
    IDLE,
    PFX0,
    PFX1,
    DIG,
    SEP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nxt;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             handshake, last_char, accept, in_ready;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // in_ready reopens during the final handshake so words stream without a gap.
  always_comb begin
    handshake = valid_q & bus.out_ready;
    last_char = (state_q == SEP) || ((state_q == DIG) && (cnt_q == '0) && !SEP_EN);
    in_ready  = !rst && ((state_q == IDLE) || (last_char && handshake));
    accept    = bus.in_valid && in_ready;
    shreg_nxt = shreg_q << 4;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    if (accept) begin
      shreg_d = bus.in_data;
      cnt_d   = 4'(NDIG - 1);
      valid_d = 1'b1;
      if (PREFIX_EN) begin
        state_d = PFX0;
        char_d  = 8'h30;
      end else begin
        state_d = DIG;
        char_d  = hex_char(bus.in_data[WIDTH-1 -: 4]);
      end
    end else if (handshake) begin
      unique case (state_q)
        PFX0: begin
          state_d = PFX1;
          char_d  = 8'h78;
        end
        PFX1: begin
          state_d = DIG;
          char_d  = hex_char(shreg_q[WIDTH-1 -: 4]);
        end
        DIG: begin
          if (cnt_q != '0) begin
            shreg_d = shreg_nxt;
            cnt_d   = cnt_q - 4'd1;
            char_d  = hex_char(shreg_nxt[WIDTH-1 -: 4]);
          end else if (SEP_EN) begin
            state_d = SEP;
            char_d  = SEP_CHAR;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        SEP: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_char  = char_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_asc_word_to_hex_stream.sv
// Self-checking bench: four serializer configurations checked against a string-based hex model.
module tb_asc_word_to_hex_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs    = 0;

  // Instance 0: W16 upper no-prefix sep; 1: W16 lower prefix no-sep; 2: W64 upper sep; 3: W4 lower prefix sep
  logic [63:0] din [4];
  logic        vin [4];
  logic        ordy[4];
  logic        rdy [4];
  logic        ov  [4];
  logic [7:0]  oc  [4];

  asc_word_to_hex_stream_if #(.WIDTH(16)) ifa ();
  asc_word_to_hex_stream_if #(.WIDTH(16)) ifb ();
  asc_word_to_hex_stream_if #(.WIDTH(64)) ifc ();
  asc_word_to_hex_stream_if #(.WIDTH(4))  ifd ();

  assign ifa.in_data = din[0][15:0]; assign ifa.in_valid = vin[0]; assign ifa.out_ready = ordy[0];
  assign ifb.in_data = din[1][15:0]; assign ifb.in_valid = vin[1]; assign ifb.out_ready = ordy[1];
  assign ifc.in_data = din[2];       assign ifc.in_valid = vin[2]; assign ifc.out_ready = ordy[2];
  assign ifd.in_data = din[3][3:0];  assign ifd.in_valid = vin[3]; assign ifd.out_ready = ordy[3];
  assign rdy[0] = ifa.in_ready; assign ov[0] = ifa.out_valid; assign oc[0] = ifa.out_char;
  assign rdy[1] = ifb.in_ready; assign ov[1] = ifb.out_valid; assign oc[1] = ifb.out_char;
  assign rdy[2] = ifc.in_ready; assign ov[2] = ifc.out_valid; assign oc[2] = ifc.out_char;
  assign rdy[3] = ifd.in_ready; assign ov[3] = ifd.out_valid; assign oc[3] = ifd.out_char;

  asc_word_to_hex_stream #(.WIDTH(16), .UPPER(1'b1), .PREFIX_EN(1'b0), .SEP_EN(1'b1), .SEP_CHAR(8'h20))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  asc_word_to_hex_stream #(.WIDTH(16), .UPPER(1'b0), .PREFIX_EN(1'b1), .SEP_EN(1'b0), .SEP_CHAR(8'h20))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  asc_word_to_hex_stream #(.WIDTH(64), .UPPER(1'b1), .PREFIX_EN(1'b0), .SEP_EN(1'b1), .SEP_CHAR(8'h20))
    u_c (.clk(clk), .rst(rst), .bus(ifc));
  asc_word_to_hex_stream #(.WIDTH(4),  .UPPER(1'b0), .PREFIX_EN(1'b1), .SEP_EN(1'b1), .SEP_CHAR(8'h20))
    u_d (.clk(clk), .rst(rst), .bus(ifd));

  function automatic int ndig(input int id);
    case (id) 0, 1: return 4; 2: return 16; default: return 1; endcase
  endfunction
  function automatic bit upper(input int id);  return (id == 0 || id == 2); endfunction
  function automatic bit pfx(input int id);    return (id == 1 || id == 3); endfunction
  function automatic bit sep(input int id);    return (id != 1); endfunction
  function automatic int nchar(input int id);
    return ndig(id) + (pfx(id) ? 2 : 0) + (sep(id) ? 1 : 0);
  endfunction

  // Reference: printf-style hex rendering of the word, then decoration.
  function automatic string model(input int id, input logic [63:0] w);
    string h, r;
    h = $sformatf("%016h", w);
    h = h.substr(16 - ndig(id), 15);
    if (upper(id)) h = h.toupper();
    r = "";
    if (pfx(id)) r = "0x";
    r = {r, h};
    if (sep(id)) r = {r, " "};
    return r;
  endfunction

  typedef struct { int id; logic [7:0] c; int unsigned cyc; logic ir; } rec_t;
  typedef struct { int id; int unsigned cyc; } acc_t;
  typedef struct { int id; logic [7:0] c0; logic [7:0] c1; logic v1; } stall_t;
  rec_t   mq[$];
  acc_t   aq[$];
  stall_t sq[$];
  logic [63:0] wq[$];

  logic       ps[4];
  logic [7:0] pc[4];
  initial for (int i = 0; i < 4; i++) begin ps[i] = 1'b0; pc[i] = '0; end

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (!rst && ov[i] && ordy[i]) mq.push_back('{i, oc[i], cyc, rdy[i]});
      if (!rst && vin[i] && rdy[i]) aq.push_back('{i, cyc});
      if (ps[i] && !rst) sq.push_back('{i, pc[i], oc[i], ov[i]});
      ps[i] = !rst && ov[i] && !ordy[i];
      pc[i] = oc[i];
    end
  end

  function automatic int cnt(input int id);
    int n = 0;
    foreach (mq[k]) if (mq[k].id == id) n++;
    return n;
  endfunction
  function automatic string get_str(input int id);
    string s = "";
    foreach (mq[k]) if (mq[k].id == id) s = $sformatf("%s%c", s, mq[k].c);
    return s;
  endfunction
  function automatic int max_gap(input int id);
    int g = 0;
    int unsigned last = 0;
    bit seen = 0;
    foreach (mq[k]) if (mq[k].id == id) begin
      if (seen && int'(mq[k].cyc - last) > g) g = int'(mq[k].cyc - last);
      last = mq[k].cyc;
      seen = 1;
    end
    return g;
  endfunction
  function automatic string exp_all(input int id);
    string s = "";
    foreach (wq[k]) s = {s, model(id, wq[k])};
    return s;
  endfunction

  // Drives wq into instance id (in_valid held across words), out_ready per bp mode.
  task automatic run_words(input int id, input int bp, output bit ok);
    int wi = 0, guard = 0, base, need;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    base = cnt(id);
    need = wq.size() * nchar(id);
    while ((wi < wq.size() || cnt(id) - base < need) && guard < 3000) begin
      @(negedge clk);
      guard++;
      ordy[id] = (bp == 0) ? 1'b1 : (bp == 1) ? 1'($urandom % 2) : pat[guard % 6];
      if (wi < wq.size()) begin
        vin[id] = 1'b1;
        din[id] = wq[wi];
      end else begin
        vin[id] = 1'b0;
        din[id] = {$urandom, $urandom};
      end
      #1;
      if (wi < wq.size() && rdy[id]) wi++;
    end
    ok = (guard < 3000);
    @(negedge clk);
    vin[id]  = 1'b0;
    ordy[id] = 1'b1;
  endtask

  function automatic void clear();
    mq.delete(); aq.delete(); sq.delete(); wq.delete();
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin vin[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rdy[i] !== 1'b0) begin errs++; $display("FAIL rst_in_ready[%0d] got %b want 0", i, rdy[i]); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rdy[i] !== 1'b1 || ov[i] !== 1'b0 || oc[i] !== 8'h00) begin
        errs++;
        $display("FAIL post_rst[%0d] got rdy=%b ov=%b oc=%h want 1 0 00", i, rdy[i], ov[i], oc[i]);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    int first, lastk, bad;
    clear();
    wq.push_back(64'h1A2F);
    run_words(0, 0, ok);
    vectors++;
    if (!ok) begin errs++; $display("FAIL basic_timeout got stuck want done"); end
    vectors++;
    if (get_str(0) != "1A2F ") begin errs++; $display("FAIL basic_str got '%s' want '1A2F '", get_str(0)); end
    vectors++;
    if (get_str(0) != exp_all(0)) begin errs++; $display("FAIL basic_model got '%s' want '%s'", get_str(0), exp_all(0)); end
    first = (mq.size() > 0 && aq.size() > 0) ? int'(mq[0].cyc - aq[0].cyc) : -1;
    vectors++;
    if (first != 1) begin errs++; $display("FAIL basic_latency got %0d want 1", first); end
    vectors++;
    if (max_gap(0) != 1) begin errs++; $display("FAIL basic_gap got %0d want 1", max_gap(0)); end
    bad = 0;
    lastk = mq.size() - 1;
    foreach (mq[k]) if (mq[k].ir !== (k == lastk)) bad++;
    vectors++;
    if (bad != 0) begin errs++; $display("FAIL basic_in_ready got %0d wrong cycles want 0", bad); end
    #1;
    vectors++;
    if (ov[0] !== 1'b0) begin errs++; $display("FAIL basic_idle_valid got %b want 0", ov[0]); end
  endtask

  task automatic test_lower_prefix();
    bit ok;
    clear();
    wq.push_back(64'hBEEF);
    run_words(1, 0, ok);
    vectors++;
    if (!ok || get_str(1) != "0xbeef") begin
      errs++; $display("FAIL lower_prefix got '%s' ok=%b want '0xbeef'", get_str(1), ok);
    end
    clear();
    repeat (6) wq.push_back({48'h0, 16'($urandom)});
    run_words(1, 1, ok);
    vectors++;
    if (!ok || get_str(1) != exp_all(1)) begin
      errs++; $display("FAIL lower_prefix_rand got '%s' want '%s'", get_str(1), exp_all(1));
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad, lastk, nst;
    for (int id = 0; id < 2; id++) begin
      clear();
      if (id == 0) wq.push_back(64'h1A2F);
      else repeat (5) wq.push_back({48'h0, 16'($urandom)});
      run_words(id, id == 0 ? 2 : 1, ok);
      vectors++;
      if (!ok || get_str(id) != exp_all(id)) begin
        errs++; $display("FAIL bp_str[%0d] got '%s' want '%s'", id, get_str(id), exp_all(id));
      end
      bad = 0;
      nst = 0;
      foreach (sq[k]) if (sq[k].id == id) begin
        nst++;
        if (sq[k].c1 !== sq[k].c0 || sq[k].v1 !== 1'b1) bad++;
      end
      vectors++;
      if (bad != 0 || (id == 0 && nst == 0)) begin
        errs++; $display("FAIL bp_hold[%0d] got %0d unstable of %0d stalls want 0", id, bad, nst);
      end
    end
    clear();
    wq.push_back(64'h1A2F);
    run_words(0, 2, ok);
    bad = 0;
    lastk = mq.size() - 1;
    foreach (mq[k]) if (mq[k].ir !== (k == lastk)) bad++;
    vectors++;
    if (bad != 0) begin errs++; $display("FAIL bp_in_ready got %0d wrong want 0", bad); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear();
    wq.push_back(64'h0000);
    wq.push_back(64'hFFFF);
    run_words(0, 0, ok);
    vectors++;
    if (!ok || get_str(0) != "0000 FFFF ") begin
      errs++; $display("FAIL b2b_str got '%s' want '0000 FFFF '", get_str(0));
    end
    vectors++;
    if (max_gap(0) != 1) begin errs++; $display("FAIL b2b_gap got %0d want 1", max_gap(0)); end
    clear();
    repeat (3) wq.push_back({$urandom, $urandom});
    run_words(2, 0, ok);
    vectors++;
    if (!ok || get_str(2) != exp_all(2) || max_gap(2) != 1) begin
      errs++; $display("FAIL b2b_w64 got '%s' gap=%0d want '%s' gap=1", get_str(2), max_gap(2), exp_all(2));
    end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    clear();
    ordy[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b1;
    din[0] = 64'h1234;
    @(negedge clk);
    vin[0] = 1'b0;
    din[0] = 64'h5678;
    for (int n = 0; n < 50 && cnt(0) < 2; n++) begin @(negedge clk); #3; end
    vectors++;
    if (cnt(0) < 2) begin errs++; $display("FAIL midrst_start got %0d chars want 2", cnt(0)); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (rdy[0] !== 1'b0) begin errs++; $display("FAIL midrst_in_ready got %b want 0", rdy[0]); end
    @(negedge clk);
    #1;
    vectors++;
    if (ov[0] !== 1'b0) begin errs++; $display("FAIL midrst_valid got %b want 0", ov[0]); end
    @(negedge clk);
    rst = 1'b0;
    clear();
    wq.push_back(64'h00A9);
    run_words(0, 0, ok);
    repeat (6) @(negedge clk);
    vectors++;
    if (!ok || get_str(0) != "00A9 ") begin
      errs++; $display("FAIL midrst_after got '%s' want '00A9 '", get_str(0));
    end
  endtask

  task automatic test_full_range();
    bit ok;
    clear();
    wq.push_back(64'h0123456789ABCDEF);
    run_words(2, 0, ok);
    vectors++;
    if (!ok || get_str(2) != "0123456789ABCDEF " || cnt(2) != 17) begin
      errs++; $display("FAIL full_range got '%s' n=%0d want '0123456789ABCDEF ' n=17", get_str(2), cnt(2));
    end
    clear();
    repeat (4) wq.push_back({$urandom, $urandom});
    run_words(2, 1, ok);
    vectors++;
    if (!ok || get_str(2) != exp_all(2)) begin
      errs++; $display("FAIL full_range_rand got '%s' want '%s'", get_str(2), exp_all(2));
    end
  endtask

  task automatic test_width4();
    bit ok;
    clear();
    for (int n = 0; n < 16; n++) wq.push_back(64'(n));
    run_words(3, 0, ok);
    vectors++;
    if (!ok || get_str(3) != exp_all(3) || max_gap(3) != 1) begin
      errs++; $display("FAIL width4 got '%s' gap=%0d want '%s' gap=1", get_str(3), max_gap(3), exp_all(3));
    end
  endtask

  task automatic test_random();
    bit ok;
    clear();
    repeat (20) wq.push_back({48'h0, 16'($urandom)});
    run_words(0, 1, ok);
    vectors++;
    if (!ok || get_str(0) != exp_all(0)) begin
      errs++; $display("FAIL random got '%s' want '%s'", get_str(0), exp_all(0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lower_prefix();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_full_range();
    test_width4();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/asc_word_to_hex_stream.md
Name: asc_word_to_hex_stream

Overview:
- Serializes a WIDTH-bit binary word into a stream of ASCII hex characters, most-significant nybble first.
- Optional "0x" prefix and optional trailing separator character.
- Valid/ready handshake on both sides. Used to dump registers/status words to a UART or debug console byte stream.
- Companion to the existing ASCII-hex-to-binary parsing logic (opposite direction).

Parameters:
- WIDTH, 32: input word width in bits; must be a multiple of 4, range 4..64. NDIG = WIDTH/4 digits.
- UPPER, 1: 1 = digits A-F emitted as 8'h41-46; 0 = a-f emitted as 8'h61-66.
- PREFIX_EN, 0: 1 = emit "0" (8'h30) then "x" (8'h78) before the digits.
- SEP_EN, 1: 1 = emit SEP_CHAR after the last digit.
- SEP_CHAR, 8'h20: separator byte.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to convert.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_char  output  8  ASCII character.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  downstream accepts out_char this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_valid=0, out_char=8'h00, state=IDLE, shift register=0.
  - in_ready=0 while rst=1; in_ready=1 on the first cycle after rst deasserts.
- States:
  - IDLE
  - PFX0: out_char=8'h30
  - PFX1: out_char=8'h78
  - DIG: digit from the top nybble of the shift register
  - SEP: out_char=SEP_CHAR
- Accept: a word is accepted on a cycle with in_valid & in_ready. in_data loads into the shift register and a digit counter loads NDIG-1.
- Next state after accept: PFX0 if PREFIX_EN, else DIG. out_valid=1 with the first char on the next cycle (1-cycle latency).
- Outputs are registered. out_char and out_valid change only on accept or on a cycle with out_valid & out_ready (handshake).
- While out_valid=1 and out_ready=0, out_char is held stable.
- Transitions, on handshake:
  - PFX0 -> PFX1 -> DIG.
  - DIG with counter>0: shift the register left by 4, decrement the counter, stay in DIG.
  - DIG with counter==0: go to SEP if SEP_EN, else end of word.
  - SEP: end of word.
- Digit mapping for nybble n (zero-extended to 8 bits before the add):
  - n<10: 8'h30+n.
  - n>=10: (UPPER ? 8'h41 : 8'h61) + (n-10).
- End of word, i.e. handshake on the last character:
  - in_ready is combinationally 1 in that same cycle, so back-to-back words need no idle gap. in_ready = (state==IDLE) | (last_char & out_valid & out_ready), forced 0 during rst.
  - If a new word is accepted that cycle, the next cycle presents its first char with out_valid=1.
  - Otherwise state=IDLE and out_valid=0 on the next cycle.
- Characters per word: NDIG + 2*PREFIX_EN + SEP_EN. Minimum NDIG=1, the WIDTH=4 case, where the counter starts at 0.
- in_data is sampled only at accept. Changes to in_data while busy are ignored.
- Reset mid-word: the word is abandoned and no further chars are emitted. out_valid=0 the cycle after rst is sampled high. Restart per the reset values.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored (upstream holds).
- Throughput with out_ready held 1: one char per clock, no bubbles across words.

Test Plan:
- Basic, WIDTH=16, UPPER=1, PREFIX_EN=0, SEP_EN=1, SEP=8'h20, out_ready=1: in_data=16'h1A2F -> out_char 31,41,32,46,20 on 5 consecutive cycles, first one cycle after accept; in_ready high on the cycle of the 20 handshake.
- Lowercase and prefix, UPPER=0, PREFIX_EN=1, SEP_EN=0, WIDTH=16, in_data=16'hBEEF -> 30,78,62,65,65,66; no separator.
- Backpressure: same as Basic with out_ready toggling 1,0,0,1,0,1... -> out_char held stable while out_ready=0, same 5-byte sequence, no drops or duplicates, in_ready=0 until the final handshake.
- Back-to-back, out_ready=1, in_valid held 1 with 16'h0000 then 16'hFFFF -> 30,30,30,30,20,46,46,46,46,20 on 10 consecutive cycles with no gap.
- Reset mid-word: assert rst after the 2nd char of 16'h1234 -> out_valid=0 the next cycle; after release, 16'h00A9 -> 30,30,41,39,20 only, with no stale "3"/"4" emitted.
- Full-range digits: WIDTH=64, in_data=64'h0123456789ABCDEF, UPPER=1 -> 30..39 then 41..46, then 20; 17 chars total.
